// File: rtl/ispm_lsu_req_queue.sv
// In-order LSU request queue in front of the ISPM controller's LSU port.
// Writes are posted, reads return in order, and only the head entry is presented downstream.
module ispm_lsu_req_queue #(
  parameter int DEPTH      = 4,
  parameter int IDX_WIDTH  = 12,
  parameter int TAG_WIDTH  = 44,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    up_req_i,
  output logic                    up_gnt_o,
  input  logic [IDX_WIDTH-1:0]    up_idx_i,
  input  logic [TAG_WIDTH-1:0]    up_tag_i,
  input  logic                    up_we_i,
  input  logic [DATA_WIDTH/8-1:0] up_be_i,
  input  logic [DATA_WIDTH-1:0]   up_wdata_i,
  input  logic [ID_WIDTH-1:0]     up_id_i,
  output logic                    up_rvalid_o,
  output logic [DATA_WIDTH-1:0]   up_rdata_o,
  output logic [ID_WIDTH-1:0]     up_rid_o,
  output logic                    dn_req_o,
  output logic [IDX_WIDTH-1:0]    dn_idx_o,
  output logic [TAG_WIDTH-1:0]    dn_tag_o,
  output logic                    dn_we_o,
  output logic [DATA_WIDTH/8-1:0] dn_be_o,
  output logic [DATA_WIDTH-1:0]   dn_wdata_o,
  output logic [ID_WIDTH-1:0]     dn_id_o,
  input  logic                    dn_gnt_i,
  input  logic                    dn_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dn_rdata_i,
  input  logic [ID_WIDTH-1:0]     dn_rid_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_WIDTH-1:0]  idx_mem   [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem   [DEPTH];
  logic                  we_mem    [DEPTH];
  logic [BE_W-1:0]       be_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
  logic [ID_WIDTH-1:0]   id_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop, stray_rsp;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full queue refuses even when the head completes this cycle (no bypass).
  assign up_gnt_o = !full && !flush_i;
  assign push     = up_req_i && up_gnt_o;

  assign dn_req_o   = !empty;
  assign dn_idx_o   = idx_mem[rd_ptr_q];
  assign dn_tag_o   = tag_mem[rd_ptr_q];
  assign dn_we_o    = we_mem[rd_ptr_q];
  assign dn_be_o    = be_mem[rd_ptr_q];
  assign dn_wdata_o = wdata_mem[rd_ptr_q];
  assign dn_id_o    = id_mem[rd_ptr_q];

  assign pop = !empty && (dn_we_o ? dn_gnt_i : (dn_rvalid_i && (dn_rid_i == dn_id_o)));

  assign stray_rsp = (dn_rvalid_i && (empty || dn_we_o || (dn_rid_i != dn_id_o)))
                   || (dn_gnt_i && empty);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Flush keeps only the head, so the write pointer snaps to just behind it.
    if (flush_i) begin
      wr_ptr_d = empty ? rd_ptr_q : rd_ptr_q + PTR_W'(1);
      count_d  = (empty || pop) ? '0 : CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem[wr_ptr_q]   <= up_idx_i;
      tag_mem[wr_ptr_q]   <= up_tag_i;
      we_mem[wr_ptr_q]    <= up_we_i;
      be_mem[wr_ptr_q]    <= up_be_i;
      wdata_mem[wr_ptr_q] <= up_wdata_i;
      id_mem[wr_ptr_q]    <= up_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_rvalid_o <= 1'b0;
      up_rdata_o  <= '0;
      up_rid_o    <= '0;
    end else begin
      up_rvalid_o <= pop && !dn_we_o;
      if (pop && !dn_we_o) begin
        up_rdata_o <= dn_rdata_i;
        up_rid_o   <= dn_id_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!stray_rsp)
        else $warning("ispm_lsu_req_queue: ignored completion that does not match the head");
    end
  end

endmodule

// File: tb/tb_ispm_lsu_req_queue.sv
// Self-checking bench for ispm_lsu_req_queue: directed scenarios then randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_ispm_lsu_req_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        up_req_i;
  logic        up_gnt_o;
  logic [11:0] up_idx_i;
  logic [43:0] up_tag_i;
  logic        up_we_i;
  logic [7:0]  up_be_i;
  logic [63:0] up_wdata_i;
  logic [1:0]  up_id_i;
  logic        up_rvalid_o;
  logic [63:0] up_rdata_o;
  logic [1:0]  up_rid_o;
  logic        dn_req_o;
  logic [11:0] dn_idx_o;
  logic [43:0] dn_tag_o;
  logic        dn_we_o;
  logic [7:0]  dn_be_o;
  logic [63:0] dn_wdata_o;
  logic [1:0]  dn_id_o;
  logic        dn_gnt_i;
  logic        dn_rvalid_i;
  logic [63:0] dn_rdata_i;
  logic [1:0]  dn_rid_i;

  typedef struct {
    logic [11:0] idx;
    logic [43:0] tag;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [1:0]  id;
  } entry_t;

  entry_t      mq[$];
  logic        exp_rvalid;
  logic [63:0] exp_rdata;
  logic [1:0]  exp_rid;
  int          checks = 0;
  int          errors = 0;

  ispm_lsu_req_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .up_req_i(up_req_i), .up_gnt_o(up_gnt_o), .up_idx_i(up_idx_i), .up_tag_i(up_tag_i),
    .up_we_i(up_we_i), .up_be_i(up_be_i), .up_wdata_i(up_wdata_i), .up_id_i(up_id_i),
    .up_rvalid_o(up_rvalid_o), .up_rdata_o(up_rdata_o), .up_rid_o(up_rid_o),
    .dn_req_o(dn_req_o), .dn_idx_o(dn_idx_o), .dn_tag_o(dn_tag_o), .dn_we_o(dn_we_o),
    .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o), .dn_id_o(dn_id_o),
    .dn_gnt_i(dn_gnt_i), .dn_rvalid_i(dn_rvalid_i), .dn_rdata_i(dn_rdata_i), .dn_rid_i(dn_rid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    flush_i = 0; up_req_i = 0; up_we_i = 0; up_idx_i = '0; up_tag_i = '0;
    up_be_i = '0; up_wdata_i = '0; up_id_i = '0;
    dn_gnt_i = 0; dn_rvalid_i = 0; dn_rdata_i = '0; dn_rid_i = '0;
  endtask

  task automatic setReq(input logic we, input logic [11:0] idx, input logic [43:0] tag,
                        input logic [7:0] be, input logic [63:0] wdata, input logic [1:0] id);
    up_req_i = 1; up_we_i = we; up_idx_i = idx; up_tag_i = tag;
    up_be_i = be; up_wdata_i = wdata; up_id_i = id;
  endtask

  task automatic setRandomReq();
    setReq(1'($urandom), 12'($urandom), {12'($urandom), 32'($urandom)}, 8'($urandom),
           {32'($urandom), 32'($urandom)}, 2'($urandom));
  endtask

  // Drive a correct completion for the model's current head, if there is one.
  task automatic completeHead();
    if (mq.size() != 0) begin
      if (mq[0].we) dn_gnt_i = 1;
      else begin
        dn_rvalid_i = 1;
        dn_rid_i    = mq[0].id;
        dn_rdata_i  = {32'($urandom), 32'($urandom)};
      end
    end
  endtask

  // Inputs are already set just after a falling edge; check outputs, advance model and clock.
  task automatic applyStimulus();
    logic   exp_gnt, pop, stray, nxt_rvalid;
    entry_t h, e;
    #1;
    exp_gnt = (mq.size() < DEPTH) && !flush_i;
    checkOutput("up_gnt", 64'(up_gnt_o), 64'(exp_gnt));
    checkOutput("dn_req", 64'(dn_req_o), 64'(mq.size() != 0));
    pop   = 0;
    stray = dn_gnt_i || dn_rvalid_i;
    if (mq.size() != 0) begin
      h = mq[0];
      checkOutput("dn_idx", 64'(dn_idx_o), 64'(h.idx));
      checkOutput("dn_tag", 64'(dn_tag_o), 64'(h.tag));
      checkOutput("dn_we", 64'(dn_we_o), 64'(h.we));
      checkOutput("dn_be", 64'(dn_be_o), 64'(h.be));
      checkOutput("dn_wdata", dn_wdata_o, h.wdata);
      checkOutput("dn_id", 64'(dn_id_o), 64'(h.id));
      pop   = h.we ? dn_gnt_i : (dn_rvalid_i && dn_rid_i == h.id);
      stray = dn_rvalid_i && !(!h.we && dn_rid_i == h.id);
    end
    checkOutput("stray_assert", 64'(dut.stray_rsp), 64'(stray));
    checkOutput("up_rvalid", 64'(up_rvalid_o), 64'(exp_rvalid));
    if (exp_rvalid) begin
      checkOutput("up_rdata", up_rdata_o, exp_rdata);
      checkOutput("up_rid", 64'(up_rid_o), 64'(exp_rid));
    end
    nxt_rvalid = pop && !h.we;
    if (nxt_rvalid) begin
      exp_rdata = dn_rdata_i;
      exp_rid   = h.id;
    end
    if (flush_i) while (mq.size() > 1) void'(mq.pop_back());
    if (pop) void'(mq.pop_front());
    if (up_req_i && exp_gnt) begin
      e.idx = up_idx_i; e.tag = up_tag_i; e.we = up_we_i;
      e.be = up_be_i; e.wdata = up_wdata_i; e.id = up_id_i;
      mq.push_back(e);
    end
    @(posedge clk_i);
    exp_rvalid = nxt_rvalid;
    @(negedge clk_i);
    clearInputs();
  endtask

  task automatic checkResetOutputs(input string tag);
    #1;
    checkOutput({tag, "_gnt"}, 64'(up_gnt_o), 64'(1));
    checkOutput({tag, "_dn_req"}, 64'(dn_req_o), 64'(0));
    checkOutput({tag, "_rvalid"}, 64'(up_rvalid_o), 64'(0));
    checkOutput({tag, "_rdata"}, up_rdata_o, 64'(0));
    checkOutput({tag, "_rid"}, 64'(up_rid_o), 64'(0));
  endtask

  initial begin
    clearInputs();
    exp_rvalid = 0; exp_rdata = '0; exp_rid = '0;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    checkResetOutputs("reset");
    @(negedge clk_i);

    $display("[TB] scenario 1: posted write");
    setReq(1, 12'h010, '0, 8'hFF, 64'hDEADBEEF_01234567, 2'd0);
    applyStimulus();
    applyStimulus();
    completeHead();
    applyStimulus();
    applyStimulus();

    $display("[TB] scenario 2: read with controller latency 3");
    setReq(0, 12'h020, 44'h1, 8'hFF, '0, 2'd1);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    dn_rvalid_i = 1; dn_rid_i = 2'd1; dn_rdata_i = 64'hCAFE;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    $display("[TB] scenario 3: fill the queue with a stalled controller");
    for (int i = 0; i < 5; i++) begin
      setRandomReq();
      applyStimulus();
    end
    repeat (2) applyStimulus();

    $display("[TB] scenario 4: full queue, head completes while requesting");
    setRandomReq();
    completeHead();
    applyStimulus();
    setRandomReq();
    applyStimulus();
    for (int i = 0; i < DEPTH + 2; i++) begin
      completeHead();
      applyStimulus();
    end

    $display("[TB] scenario 5: flush keeps only the head");
    for (int i = 0; i < 3; i++) begin
      setReq(0, 12'($urandom), 44'($urandom), 8'hFF, '0, 2'(i));
      applyStimulus();
    end
    flush_i = 1;
    setRandomReq();
    applyStimulus();
    completeHead();
    applyStimulus();
    repeat (3) applyStimulus();

    $display("[TB] scenario 6: out-of-order read id is ignored");
    setReq(0, 12'h100, 44'h2, 8'hFF, '0, 2'd2);
    applyStimulus();
    setReq(0, 12'h200, 44'h3, 8'hFF, '0, 2'd3);
    applyStimulus();
    dn_rvalid_i = 1; dn_rid_i = 2'd3; dn_rdata_i = 64'h3333;
    applyStimulus();
    dn_rvalid_i = 1; dn_rid_i = 2'd2; dn_rdata_i = 64'h2222;
    applyStimulus();
    dn_rvalid_i = 1; dn_rid_i = 2'd3; dn_rdata_i = 64'h3333;
    applyStimulus();
    repeat (2) applyStimulus();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) setRandomReq();
      if ($urandom_range(0, 2) == 0) completeHead();
      if ($urandom_range(0, 19) == 0) flush_i = 1;
      applyStimulus();
    end

    $display("[TB] reset mid-operation");
    setRandomReq();
    applyStimulus();
    setRandomReq();
    applyStimulus();
    rst_i = 1;
    checkResetOutputs("midreset");
    mq.delete();
    exp_rvalid = 0; exp_rdata = '0; exp_rid = '0;
    @(negedge clk_i);
    rst_i = 0;
    dn_rvalid_i = 1; dn_rid_i = 2'd0; dn_rdata_i = 64'h5555;
    applyStimulus();
    repeat (2) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
